// File: rtl/ff_sync_pkg.sv
// rtl/ff_sync_pkg.sv - shared helpers and widths for the PCS synchronizer blocks
package ff_sync_pkg;

    localparam int GLITCH_W = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Filter counter must hold 0..filt_cnt; never narrower than one bit.
    function automatic int filt_cnt_w(input int filt_cnt);
        int w;
        w = clog2(filt_cnt + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ff_sync_filter_bank_chan.sv
// rtl/ff_sync_filter_bank_chan.sv - one channel: sync chain, stability filter, edge pulses (FF_SYNC_GLITCH_STATS_EN adds glitch counter)
module ff_sync_filter_chan
    import ff_sync_pkg::*;
#(
    parameter int   C_NUM_SYNC_REGS = 3,
    parameter int   C_FILT_CNT      = 4,
    parameter logic C_RVAL          = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_in,
    output logic                data_out,
    output logic                rise,
    output logic                fall,
    output logic                change_next,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CW = filt_cnt_w(C_FILT_CNT);

    (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
    logic [C_NUM_SYNC_REGS-1:0] chain;
    logic [CW-1:0]              cnt;
    logic                       s;
    logic                       accept;

    assign s = chain[C_NUM_SYNC_REGS-1];

    // New value has differed for C_FILT_CNT consecutive cycles: take it this edge.
    always_comb begin
        accept = (s != data_out) && (cnt == CW'(C_FILT_CNT - 1));
    end

    assign change_next = accept;

    // Metastability chain; only the last stage is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {C_NUM_SYNC_REGS{C_RVAL}};
        end else begin
            chain <= {chain[C_NUM_SYNC_REGS-2:0], data_in};
        end
    end

    // Stability filter and registered edge pulses; a run that breaks early is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            data_out <= C_RVAL;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= accept & s;
            fall <= accept & ~s;
            if (accept) begin
                data_out <= s;
                cnt      <= '0;
            end else if (s != data_out) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

`ifdef FF_SYNC_GLITCH_STATS_EN
    logic                glitch;
    logic [GLITCH_W-1:0] gcnt;

    always_comb begin
        glitch = (s == data_out) && (cnt != '0);
    end

    // Saturating count of rejected transitions, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt <= '0;
        end else if (glitch && (gcnt != {GLITCH_W{1'b1}})) begin
            gcnt <= gcnt + 1'b1;
        end
    end

    assign glitch_cnt = gcnt;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: rtl/ff_sync_filter_bank.sv
// rtl/ff_sync_filter_bank.sv - multi-channel filtered synchronizer bank (FF_SYNC_GLITCH_STATS_EN enables glitch counters)
module ff_sync_filter_bank
    import ff_sync_pkg::*;
#(
    parameter int                 C_WIDTH         = 4,
    parameter int                 C_NUM_SYNC_REGS = 3,
    parameter logic [C_WIDTH-1:0] C_RVAL          = '0,
    parameter int                 C_FILT_CNT      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [C_WIDTH-1:0]            data_in,
    output logic [C_WIDTH-1:0]            data_out,
    output logic [C_WIDTH-1:0]            rise,
    output logic [C_WIDTH-1:0]            fall,
    output logic                          any_change,
    output logic [GLITCH_W*C_WIDTH-1:0]   glitch_cnt
);

    logic [C_WIDTH-1:0] chg_next;

    for (genvar i = 0; i < C_WIDTH; i++) begin : g_chan
        ff_sync_filter_chan #(
            .C_NUM_SYNC_REGS (C_NUM_SYNC_REGS),
            .C_FILT_CNT      (C_FILT_CNT),
            .C_RVAL          (C_RVAL[i])
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .data_in     (data_in[i]),
            .data_out    (data_out[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .change_next (chg_next[i]),
            .glitch_cnt  (glitch_cnt[GLITCH_W*i +: GLITCH_W])
        );
    end

    // Single summary pulse, registered on the same edge as the per-channel pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |chg_next;
        end
    end

endmodule

// File: tb/tb_ff_sync_filter_bank.sv
// tb/tb_ff_sync_filter_bank.sv - directed and model-checked bench for ff_sync_filter_bank
module tb_ff_sync_filter_bank;

    localparam int         N      = 3;
    localparam int         F      = 4;
    localparam logic [3:0] RVAL_A = 4'b1010;

    logic        clk;
    logic        rst;
    logic [3:0]  data_in;
    logic [3:0]  data_out;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic        any_change;
    logic [31:0] glitch_cnt;

    logic        data_in_b;
    logic        data_out_b;
    logic        rise_b;
    logic        fall_b;
    logic        any_change_b;
    logic [7:0]  glitch_cnt_b;

    int checks = 0;
    int errors = 0;

    ff_sync_filter_bank #(
        .C_WIDTH(4), .C_NUM_SYNC_REGS(N), .C_RVAL(RVAL_A), .C_FILT_CNT(F)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
        .rise(rise), .fall(fall), .any_change(any_change), .glitch_cnt(glitch_cnt)
    );

    ff_sync_filter_bank #(
        .C_WIDTH(1), .C_NUM_SYNC_REGS(2), .C_RVAL(1'b0), .C_FILT_CNT(1)
    ) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in_b), .data_out(data_out_b),
        .rise(rise_b), .fall(fall_b), .any_change(any_change_b), .glitch_cnt(glitch_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model of the 4-channel instance.
    logic [N-1:0] m_chain [4];
    int           m_cnt   [4];
    logic [7:0]   m_gl    [4];
    logic [3:0]   m_out, m_rise, m_fall;
    logic         m_any;

    always @(posedge clk) begin
        logic s;
        logic any_n;
        any_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_chain[i] <= {N{RVAL_A[i]}};
                m_cnt[i]   <= 0;
                m_gl[i]    <= 8'd0;
                m_out[i]   <= RVAL_A[i];
                m_rise[i]  <= 1'b0;
                m_fall[i]  <= 1'b0;
            end else begin
                s = m_chain[i][N-1];
                m_chain[i] <= {m_chain[i][N-2:0], data_in[i]};
                m_rise[i]  <= 1'b0;
                m_fall[i]  <= 1'b0;
                if (s != m_out[i]) begin
                    if (m_cnt[i] == F - 1) begin
                        m_out[i]  <= s;
                        m_cnt[i]  <= 0;
                        m_rise[i] <= s;
                        m_fall[i] <= ~s;
                        any_n = 1'b1;
                    end else begin
                        m_cnt[i] <= m_cnt[i] + 1;
                    end
                end else if (m_cnt[i] != 0) begin
                    m_cnt[i] <= 0;
`ifdef FF_SYNC_GLITCH_STATS_EN
                    if (m_gl[i] != 8'hFF) m_gl[i] <= m_gl[i] + 8'd1;
`endif
                end
            end
        end
        m_any <= rst ? 1'b0 : any_n;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] g_exp1;
        logic [31:0] g_expsat;
`ifdef FF_SYNC_GLITCH_STATS_EN
        g_exp1   = 32'h0000_0100;
        g_expsat = 32'h0000_FF00;
`else
        g_exp1   = 32'h0;
        g_expsat = 32'h0;
`endif
        rst       = 1'b1;
        data_in   = 4'b0101;
        data_in_b = 1'b0;

        // 1: reset state, then release and qualify 0101
        tick(3);
        chk("t1_rst_out", data_out, 4'b1010);
        chk("t1_rst_pulses", {rise, fall, any_change}, 9'd0);
        chk("t1_rst_glitch", glitch_cnt, 32'd0);
        chk("t1_rst_b", {data_out_b, rise_b, fall_b, any_change_b, glitch_cnt_b}, 12'd0);
        rst = 1'b0;
        tick(6);
        chk("t1_hold_out", data_out, 4'b1010);
        chk("t1_hold_any", any_change, 1'b0);
        tick(1);
        chk("t1_edge7_out", data_out, 4'b0101);
        chk("t1_edge7_rise", rise, 4'b0101);
        chk("t1_edge7_fall", fall, 4'b1010);
        chk("t1_edge7_any", any_change, 1'b1);
        tick(1);
        chk("t1_pulse_end", {rise, fall, any_change}, 9'd0);

        // 2: ch0 down then 0->1 step latency
        data_in = 4'b0100;
        tick(7);
        chk("t2_fall0", {data_out, fall}, {4'b0100, 4'b0001});
        tick(1);
        data_in = 4'b0101;
        tick(6);
        chk("t2_before7", data_out, 4'b0100);
        tick(1);
        chk("t2_at7", {data_out, rise, fall, any_change}, {4'b0101, 4'b0001, 4'b0000, 1'b1});
        tick(1);
        chk("t2_after", {rise, fall, any_change}, 9'd0);

        // 3: 3-cycle glitch on ch1 is rejected, then saturate the counter
        data_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("t3_nopulse", {data_out, rise, fall, any_change}, {4'b0101, 9'd0});
        end
        data_in[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk("t3_nopulse", {data_out, rise, fall, any_change}, {4'b0101, 9'd0});
        end
        chk("t3_glitch1", glitch_cnt, g_exp1);
        for (int g = 0; g < 300; g++) begin
            data_in[1] = 1'b1;
            tick(3);
            data_in[1] = 1'b0;
            tick(4);
        end
        tick(4);
        chk("t3_sat_out", data_out, 4'b0101);
        chk("t3_sat_cnt", glitch_cnt, g_expsat);

        // 4: reset mid-qualification, then full requalification
        data_in = 4'b0001;
        tick(4);
        chk("t4_partial", data_out, 4'b0101);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t4_rst_out", data_out, RVAL_A);
        chk("t4_rst_clr", {rise, fall, any_change, glitch_cnt}, 41'd0);
        tick(1);
        chk("t4_release_nopulse", {rise, fall, any_change}, 9'd0);
        tick(5);
        chk("t4_before7", data_out, RVAL_A);
        tick(1);
        chk("t4_at7", {data_out, rise, fall, any_change}, {4'b0001, 4'b0001, 4'b1010, 1'b1});

        // 5: boundary instance, 2 stages and transparent filter
        data_in_b = 1'b1;
        tick(2);
        chk("t5_before3", data_out_b, 1'b0);
        tick(1);
        chk("t5_at3", {data_out_b, rise_b, fall_b, any_change_b}, 4'b1101);
        tick(1);
        chk("t5_after", {data_out_b, rise_b, any_change_b, glitch_cnt_b}, 11'b100_0000_0000);

        // 6: random toggling against the reference model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) data_in[b] = ~data_in[b];
            end
            tick(1);
            chk("t6_model",
                {data_out, rise, fall, any_change, glitch_cnt},
                {m_out, m_rise, m_fall, m_any, m_gl[3], m_gl[2], m_gl[1], m_gl[0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
